// File: rtl/bch_decode_sequencer_if.sv
// rtl/bch_decode_sequencer_if.sv - word-in / result-out handshake bundle for the BCH(15,7) sequencer
//
// Purpose: groups the input word handshake and the result handshake into one interface.
// Signals:
//   in_valid   producer -> sequencer  in_word valid
//   in_ready   sequencer -> producer  sequencer can accept a word
//   in_word    producer -> sequencer  received 15-bit codeword (bit i = coefficient of x^i)
//   out_valid  sequencer -> consumer  result valid
//   out_ready  consumer -> sequencer  consumer accepts result
//   out_msg    sequencer -> consumer  corrected message (corrected word [14:8])
//   out_status sequencer -> consumer  0 clean, 1 one fixed, 2 two fixed, 3 uncorrectable
// Modports: master = producer/consumer side, slave = sequencer side.
interface bch_decode_sequencer_if #(
  parameter int MSG_W = 7,
  parameter int CW_W  = 15
);
  logic             in_valid;
  logic             in_ready;
  logic [CW_W-1:0]  in_word;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_msg;
  logic [1:0]       out_status;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_msg, out_status
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_msg, out_status
  );
endinterface

// File: rtl/bch_decode_sequencer.sv
// rtl/bch_decode_sequencer.sv - bit-serial BCH(15,7,t=2) decode sequencer over GF(16)
//
// Purpose: accepts one received word, accumulates S1/S3 serially (15 cycles), solves the
//   error locator (1 cycle), runs a serial Chien search (15 cycles), then presents the
//   corrected 7-bit message and a status code until the consumer accepts it.
//   GF(16) uses x^4+x+1 with alpha = 4'd2; generator polynomial 9'h1D1.
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   bch_decode_sequencer_if.slave (in_valid/in_ready/in_word, out_valid/out_ready/
//         out_msg/out_status)
//   busy  high in any state other than IDLE
// Optional feature macro: BCH_SEQ_EARLY_EXIT_EN - a word with S1 = S3 = 0 at the end of the
//   syndrome phase goes straight to DONE with status 0 (latency 16 instead of 32).
module bch_decode_sequencer #(
  parameter int MSG_W = 7,
  parameter int CW_W  = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  bch_decode_sequencer_if.slave        bus,
  output logic                         busy
);

  typedef enum logic [2:0] {IDLE, SYND, LOC, CHIEN, DONE} state_t;

  localparam logic [CW_W-1:0] ONE_HOT0 = {{(CW_W-1){1'b0}}, 1'b1};

  // multiply by alpha: shift up, fold x^4 back as x+1
  function automatic logic [3:0] gf_mul_a(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // multiply by alpha^-1 = alpha^3 + 1: shift down, fold x^-1 back as x^3+1
  function automatic logic [3:0] gf_div_a(input logic [3:0] a);
    return {1'b0, a[3:1]} ^ (a[0] ? 4'h9 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_exp(input logic [3:0] e);
    case (e)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h4;
      4'd3:    return 4'h8;
      4'd4:    return 4'h3;
      4'd5:    return 4'h6;
      4'd6:    return 4'hC;
      4'd7:    return 4'hB;
      4'd8:    return 4'h5;
      4'd9:    return 4'hA;
      4'd10:   return 4'h7;
      4'd11:   return 4'hE;
      4'd12:   return 4'hF;
      4'd13:   return 4'hD;
      4'd14:   return 4'h9;
      default: return 4'h1;
    endcase
  endfunction

  // log of zero is undefined; callers guard zero operands
  function automatic logic [3:0] gf_log(input logic [3:0] v);
    case (v)
      4'h1:    return 4'd0;
      4'h2:    return 4'd1;
      4'h4:    return 4'd2;
      4'h8:    return 4'd3;
      4'h3:    return 4'd4;
      4'h6:    return 4'd5;
      4'hC:    return 4'd6;
      4'hB:    return 4'd7;
      4'h5:    return 4'd8;
      4'hA:    return 4'd9;
      4'h7:    return 4'd10;
      4'hE:    return 4'd11;
      4'hF:    return 4'd12;
      4'hD:    return 4'd13;
      4'h9:    return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // exponent sums here never exceed 44, so two conditional subtractions suffice
  function automatic logic [3:0] mod15(input logic [5:0] v);
    logic [5:0] r;
    r = v;
    if (r >= 6'd30)      r = r - 6'd30;
    else if (r >= 6'd15) r = r - 6'd15;
    return 4'(r);
  endfunction

  function automatic logic [3:0] gf_cube(input logic [3:0] a);
    if (a == 4'h0) return 4'h0;
    return gf_exp(mod15(6'(gf_log(a)) * 6'd3));
  endfunction

  function automatic logic [3:0] gf_div(input logic [3:0] n, input logic [3:0] d);
    if (n == 4'h0 || d == 4'h0) return 4'h0;
    return gf_exp(mod15(6'(gf_log(n)) + 6'd15 - 6'(gf_log(d))));
  endfunction

  state_t           state_q;
  logic [CW_W-1:0]  word_q;
  logic [CW_W-1:0]  raw_q;
  logic [3:0]       s1_q, s3_q;
  logic [3:0]       sigma1_q, sigma2_q;
  logic [3:0]       t1_q, t2_q;
  logic [3:0]       cnt_q;
  logic [1:0]       roots_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic [MSG_W-1:0] out_msg_q;
  logic [1:0]       out_status_q;

  logic [3:0]       s1_d, s3_d, sigma2_d, eval_d;
  logic [CW_W-1:0]  word_d;
  logic [1:0]       roots_d, status_d;
  logic             root_hit;

  always_comb begin
    s1_d     = gf_mul_a(s1_q) ^ {3'b000, word_q[cnt_q]};
    s3_d     = gf_mul_a(gf_mul_a(gf_mul_a(s3_q))) ^ {3'b000, word_q[cnt_q]};
    sigma2_d = (s1_q == 4'h0) ? 4'h0 : gf_div(s3_q ^ gf_cube(s1_q), s1_q);

    // sigma(alpha^-cnt) = 0 marks an error at bit position cnt
    eval_d   = 4'h1 ^ t1_q ^ t2_q;
    root_hit = (eval_d == 4'h0);
    word_d   = root_hit ? (word_q ^ (ONE_HOT0 << cnt_q)) : word_q;
    roots_d  = (root_hit && roots_q != 2'd3) ? roots_q + 2'd1 : roots_q;

    // root count must match the locator degree, otherwise the pattern is beyond t=2
    if (sigma1_q == 4'h0 && s3_q == 4'h0)        status_d = 2'd0;
    else if (sigma1_q == 4'h0)                   status_d = 2'd3;
    else if (sigma2_q == 4'h0 && roots_d == 2'd1) status_d = 2'd1;
    else if (sigma2_q != 4'h0 && roots_d == 2'd2) status_d = 2'd2;
    else                                         status_d = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      raw_q        <= '0;
      s1_q         <= '0;
      s3_q         <= '0;
      sigma1_q     <= '0;
      sigma2_q     <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      cnt_q        <= '0;
      roots_q      <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      out_msg_q    <= '0;
      out_status_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            word_q     <= bus.in_word;
            raw_q      <= bus.in_word;
            s1_q       <= '0;
            s3_q       <= '0;
            roots_q    <= '0;
            cnt_q      <= 4'd14;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SYND;
          end
        end
        SYND: begin
          s1_q <= s1_d;
          s3_q <= s3_d;
          if (cnt_q == 4'd0) begin
`ifdef BCH_SEQ_EARLY_EXIT_EN
            if (s1_d == 4'h0 && s3_d == 4'h0) begin
              out_valid_q  <= 1'b1;
              out_msg_q    <= word_q[CW_W-1:CW_W-MSG_W];
              out_status_q <= 2'd0;
              state_q      <= DONE;
            end else begin
              state_q <= LOC;
            end
`else
            state_q <= LOC;
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        LOC: begin
          sigma1_q <= s1_q;
          sigma2_q <= sigma2_d;
          t1_q     <= s1_q;
          t2_q     <= sigma2_d;
          cnt_q    <= 4'd0;
          state_q  <= CHIEN;
        end
        CHIEN: begin
          word_q  <= word_d;
          roots_q <= roots_d;
          t1_q    <= gf_div_a(t1_q);
          t2_q    <= gf_div_a(gf_div_a(t2_q));
          if (cnt_q == 4'd14) begin
            out_valid_q  <= 1'b1;
            out_status_q <= status_d;
            if (status_d == 2'd3) begin
              word_q    <= raw_q;
              out_msg_q <= raw_q[CW_W-1:CW_W-MSG_W];
            end else begin
              out_msg_q <= word_d[CW_W-1:CW_W-MSG_W];
            end
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_msg    = out_msg_q;
  assign bus.out_status = out_status_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_bch_decode_sequencer.sv
// tb/tb_bch_decode_sequencer.sv - scoreboard bench for bch_decode_sequencer
module tb_bch_decode_sequencer;

`ifdef BCH_SEQ_EARLY_EXIT_EN
  localparam int CLEAN_LAT = 16;
`else
  localparam int CLEAN_LAT = 32;
`endif
  localparam int FULL_LAT = 32;

  typedef struct {
    logic [6:0] msg;
    logic [1:0] status;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  bch_decode_sequencer_if bus_if ();

  bch_decode_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_if.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // systematic encoder: message in [14:8], parity = x^8*m(x) mod g(x)
  function automatic logic [14:0] encode(input logic [6:0] m);
    logic [14:0] rem;
    rem = {m, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (rem[i]) rem = rem ^ (15'h01D1 << (i - 8));
    return {m, rem[7:0]};
  endfunction

  // nearest-codeword search over all 128 messages: {status, msg}
  function automatic logic [8:0] model(input logic [14:0] r);
    int         best_d;
    int         d;
    logic [6:0] best_m;
    best_d = 99;
    best_m = r[14:8];
    for (int m = 0; m < 128; m++) begin
      d = $countones(encode(7'(m)) ^ r);
      if (d < best_d) begin
        best_d = d;
        best_m = 7'(m);
      end
    end
    if (best_d <= 2) return {2'(best_d), best_m};
    return {2'd3, r[14:8]};
  endfunction

  task automatic send(input logic [14:0] w, input logic [6:0] em, input logic [1:0] es,
                      input bit push);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!bus_if.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_if.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_word  = w;
    @(posedge clk);
    #1;
    accept_cyc      = cyc;
    bus_if.in_valid = 1'b0;
    bus_if.in_word  = 15'($urandom);
    if (push) begin
      e.msg    = em;
      e.status = es;
      e.lat    = (es == 2'd0) ? CLEAN_LAT : FULL_LAT;
      sb_q.push_back(e);
    end
  endtask

  task automatic send_model(input logic [14:0] w);
    logic [8:0] m;
    m = model(w);
    send(w, m[6:0], m[8:7], 1'b1);
  endtask

  task automatic collect(input int hold);
    int   waited;
    int   lat;
    exp_t e;
    waited = 0;
    bus_if.out_ready = (hold == 0);
    @(negedge clk);
    while (!bus_if.out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_if.out_valid) begin
      check("out_timeout", 32'd0, 32'd1);
      return;
    end
    lat = cyc - accept_cyc + 1;
    if (sb_q.size() == 0) begin
      check("sb_unexpected_output", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("msg", 32'(bus_if.out_msg), 32'(e.msg));
      check("status", 32'(bus_if.out_status), 32'(e.status));
      check("latency", 32'(lat), 32'(e.lat));
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", 32'(bus_if.out_valid), 32'd1);
        check("hold_msg", 32'(bus_if.out_msg), 32'(e.msg));
        check("hold_status", 32'(bus_if.out_status), 32'(e.status));
        check("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
        @(negedge clk);
      end
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop", 32'(bus_if.out_valid), 32'd0);
    check("ready_back", 32'(bus_if.in_ready), 32'd1);
  endtask

  initial begin
    int          prev_acc;
    logic [14:0] w;
    bus_if.in_valid  = 1'b0;
    bus_if.in_word   = '0;
    bus_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_out_msg", 32'(bus_if.out_msg), 32'd0);
    check("rst_out_status", 32'(bus_if.out_status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // clean word, then a back-to-back word to measure the accept period
    send(15'h01D1, 7'h01, 2'd0, 1'b1);
    collect(0);
    prev_acc = accept_cyc;
    send(15'h4000, 7'h00, 2'd1, 1'b1);
    check("period", 32'(accept_cyc - prev_acc), 32'(CLEAN_LAT + 1));
    collect(0);

    // every single-bit error on the all-zero codeword
    for (int i = 0; i < 15; i++) begin
      send(15'd1 << i, 7'h00, 2'd1, 1'b1);
      collect(0);
    end

    send(15'h41D0, 7'h01, 2'd2, 1'b1);
    collect(0);
    send(15'h0013, 7'h00, 2'd3, 1'b1);
    collect(0);

    // backpressure: result held for 10 cycles
    send(15'h41D0, 7'h01, 2'd2, 1'b1);
    collect(10);

    // a second in_valid during SYND must be ignored
    send(15'h01D1 ^ 15'h0200, 7'h01, 2'd1, 1'b1);
    repeat (3) @(negedge clk);
    check("synd_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("synd_busy", 32'(busy), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_word  = 15'h0013;
    @(posedge clk);
    #1 bus_if.in_valid = 1'b0;
    collect(0);
    send(encode(7'h55), 7'h55, 2'd0, 1'b1);
    collect(0);

    // reset during CHIEN abandons the word
    send(15'h4001, 7'h00, 2'd2, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    send(encode(7'h2A) ^ 15'h0081, 7'h2A, 2'd2, 1'b1);
    collect(0);

    // random messages with 0..4 flipped bits, plus raw random words
    for (int n = 0; n < 25; n++) begin
      w = encode(7'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 4)) w = w ^ (15'd1 << $urandom_range(0, 14));
      send_model(w);
      collect(n % 7 == 3 ? 2 : 0);
    end
    for (int n = 0; n < 6; n++) begin
      send_model(15'($urandom));
      collect(0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
